// File: rtl/reg_file_wb_if.sv
// reg_file_wb_if: register-file bus bundle (write port, two read ports, debug port, write counter)
interface reg_file_wb_if #(parameter int DW = 32, parameter int AW = 5);
  logic          RFWr;
  logic [AW-1:0] RS1;
  logic [AW-1:0] RS2;
  logic [AW-1:0] WA;
  logic [DW-1:0] WD;
  logic [DW-1:0] RS1out;
  logic [DW-1:0] RS2out;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic [15:0]   wr_cnt;
  modport master (output RFWr, RS1, RS2, WA, WD, dbg_addr, input RS1out, RS2out, dbg_data, wr_cnt);
  modport slave  (input RFWr, RS1, RS2, WA, WD, dbg_addr, output RS1out, RS2out, dbg_data, wr_cnt);
endinterface

// File: rtl/reg_file_wb.sv
// reg_file_wb: MIPS write-back register file, $0 hardwired to zero; define RF_WB_BYPASS_EN for write-through reads
module reg_file_wb #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input logic           clk,
  input logic           rst,
  reg_file_wb_if.slave  bus
);
  logic [DW-1:0] regs_q [2**AW];
  logic [15:0]   wr_cnt_q, wr_cnt_d;
  logic          we;
  // A write commits only to a nonzero address; the counter wraps naturally at 16 bits
  always_comb begin
    we       = bus.RFWr && (bus.WA != '0);
    wr_cnt_d = we ? wr_cnt_q + 16'd1 : wr_cnt_q;
  end
  // Storage and counter; reset wins over a write in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q   <= '{default: '0};
      wr_cnt_q <= '0;
    end else begin
      if (we) regs_q[bus.WA] <= bus.WD;
      wr_cnt_q <= wr_cnt_d;
    end
  end
  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a, input logic [DW-1:0] stored,
                                       input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
`ifdef RF_WB_BYPASS_EN
    rd = (a == '0) ? '0 : (w && a == wa) ? wd : stored;
`else
    rd = (a == '0) ? '0 : stored;
`endif
  endfunction
  // Combinational read ports
  always_comb begin
    bus.RS1out   = rd(bus.RS1, regs_q[bus.RS1], we, bus.WA, bus.WD);
    bus.RS2out   = rd(bus.RS2, regs_q[bus.RS2], we, bus.WA, bus.WD);
    bus.dbg_data = rd(bus.dbg_addr, regs_q[bus.dbg_addr], we, bus.WA, bus.WD);
    bus.wr_cnt   = wr_cnt_q;
  end
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: randomized self-checking bench for reg_file_wb against an array-based model
module tb_reg_file_wb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [31:0] mdl [32];
  int unsigned cnt = 0;
  reg_file_wb_if #(.DW(32), .AW(5)) b ();
  reg_file_wb #(.DW(32), .AW(5)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic w, input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef RF_WB_BYPASS_EN
    if (w && wa != 5'd0 && a == wa) return wd;
`endif
    return mdl[a];
  endfunction
  task automatic cycle(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad, input bit chkrd);
    rst = r; b.RFWr = w; b.WA = wa; b.WD = wd; b.RS1 = a1; b.RS2 = a2; b.dbg_addr = ad;
    @(negedge clk);
    if (chkrd) begin
      chk("rfwr_known", {31'd0, $isunknown(b.RFWr)}, 32'd0);
      chk("rs1out", b.RS1out, exp_rd(a1, w, wa, wd));
      chk("rs2out", b.RS2out, exp_rd(a2, w, wa, wd));
      chk("dbg_data", b.dbg_data, exp_rd(ad, w, wa, wd));
      chk("wr_cnt", {16'd0, b.wr_cnt}, cnt);
    end
    @(posedge clk);
    if (r) begin
      foreach (mdl[i]) mdl[i] = 32'd0;
      cnt = 0;
    end else if (w && wa != 5'd0) begin
      mdl[wa] = wd;
      cnt = (cnt + 1) % 65536;
    end
    #1;
  endtask
  task automatic rnd_cycle(input bit allow_rst);
    cycle(allow_rst && $urandom_range(49, 0) == 0, 1'($urandom), 5'($urandom), $urandom,
          5'($urandom), 5'($urandom), 5'($urandom), 1'b1);
  endtask
  initial begin
    foreach (mdl[i]) mdl[i] = 32'd0;
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 20; i++) rnd_cycle(1'b0);
    cycle(1'b1, 1'b1, 5'($urandom), $urandom, 5'd0, 5'd0, 5'd0, 1'b0);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(i), 5'(i), 1'b0);
      chk("reset_rs1", b.RS1out, 32'd0);
      chk("reset_rs2", b.RS2out, 32'd0);
      chk("reset_dbg", b.dbg_data, 32'd0);
      chk("reset_cnt", {16'd0, b.wr_cnt}, 32'd0);
    end
    cycle(1'b0, 1'b1, 5'd5, 32'h1234ABCD, 5'd0, 5'd0, 5'd0, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5, 1'b1);
    chk("basic_rs1", b.RS1out, 32'h1234ABCD);
    chk("basic_rs2", b.RS2out, 32'h1234ABCD);
    chk("basic_cnt", {16'd0, b.wr_cnt}, 32'd1);
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    chk("zero_rs1", b.RS1out, 32'd0);
    chk("zero_cnt", {16'd0, b.wr_cnt}, 32'd1);
    cycle(1'b0, 1'b1, 5'd8, 32'h11, 5'd0, 5'd0, 5'd0, 1'b1);
    rst = 1'b0; b.RFWr = 1'b1; b.WA = 5'd8; b.WD = 32'h22; b.RS1 = 5'd8; b.RS2 = 5'd0; b.dbg_addr = 5'd8;
    #1;
`ifdef RF_WB_BYPASS_EN
    chk("rdw_before", b.RS1out, 32'h22);
`else
    chk("rdw_before", b.RS1out, 32'h11);
`endif
    cycle(1'b0, 1'b1, 5'd8, 32'h22, 5'd8, 5'd0, 5'd8, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd8, 5'd8, 1'b1);
    chk("rdw_after", b.RS1out, 32'h22);
    cycle(1'b0, 1'b1, 5'd31, 32'h77, 5'd0, 5'd0, 5'd0, 1'b1);
    cycle(1'b1, 1'b1, 5'd31, 32'h8, 5'd0, 5'd0, 5'd0, 1'b0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd31, 5'd31, 1'b1);
    chk("rstpri_reg31", b.dbg_data, 32'd0);
    chk("rstpri_cnt", {16'd0, b.wr_cnt}, 32'd0);
    for (int i = 0; i < 400; i++) rnd_cycle(1'b1);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 65536; i++)
      cycle(1'b0, 1'b1, (i % 2 == 0) ? 5'd31 : 5'd2, (i % 2 == 0) ? 32'h00003004 : $urandom,
            5'd31, 5'd2, 5'd31, i >= 65534);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd2, 5'd31, 1'b1);
    chk("wrap_cnt", {16'd0, b.wr_cnt}, 32'd0);
    chk("wrap_link", b.dbg_data, 32'h00003004);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Write-back stage and general-purpose register file of the single-cycle MIPS datapath.
- Consumes the write-back mux output (selected ALU/DM/PC+4/ext data) as write data, and the destination-register mux output (rt/rd/$31) as write address.
- Provides the two source operands RS1out/RS2out to the ALU stage.
- 32 x 32-bit storage, $0 hardwired to zero, plus a debug read port for the bench and board display.

Parameters:
- DW, 32, data width of each register.
- AW, 5, register address width; depth = 2**AW.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- RFWr  input  1  register write enable from control unit.
- RS1  input  AW  read address port 1 (instr[25:21]).
- RS2  input  AW  read address port 2 (instr[20:16]).
- WA  input  AW  write address (destination-register mux output).
- WD  input  DW  write data (write-back mux output).
- RS1out  output  DW  read data port 1.
- RS2out  output  DW  read data port 2.
- dbg_addr  input  AW  debug read address.
- dbg_data  output  DW  debug read data.
- wr_cnt  output  16  count of committed writes (excludes writes to $0).

Behaviour:
- Clocking: single clock clk; reset rst is synchronous and active-high; no other clock or async path.
- Reset: on a rising clk with rst=1, all 32 registers clear to 0 and wr_cnt clears to 0. rst has priority over RFWr in the same cycle.
- Write: on a rising clk with rst=0, RFWr=1 and WA!=0, reg[WA] <= WD and wr_cnt <= wr_cnt+1.
- Writes to $0: a write with WA=0 is discarded and wr_cnt is unchanged.
- wr_cnt width: wraps modulo 2^16 (0xFFFF+1 -> 0x0000), no saturation.
- Read ports: combinational, zero latency. RS1out = reg[RS1]; RS2out = reg[RS2]; dbg_data = reg[dbg_addr].
- Address 0: any read port addressing 0 returns 0 regardless of history.
- Read-during-write, base build: a read of WA in the same cycle as its write returns the OLD value. The new value is visible from the cycle after the edge.
- Same port addresses: RS1=RS2 is legal, and both outputs carry the same value.
- Undefined inputs: X on RFWr while rst=0 is a verification error; the bench flags it and the RTL need not handle it.
- Reset mid-program: takes effect on the next edge. A write presented in that cycle is lost, and outputs read 0 from the following cycle.
- Post-reset outputs: RS1out=RS2out=dbg_data=0 combinationally, since all registers are 0.
- Widths: WD stored verbatim; no sign or zero extension inside the block.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- When defined: write-through bypass on each read port (RS1out, RS2out, dbg_data). If RFWr=1, WA!=0 and the port address equals WA, the port returns WD combinationally in the same cycle. Address 0 still returns 0.
- When undefined: old-value semantics as stated in Behaviour.
- Storage, reset and wr_cnt behaviour are identical in both builds.

Test Plan:
- Reset clear: hold rst=1 for 2 cycles after arbitrary writes -> RS1out=RS2out=dbg_data=0 for all 32 addresses; wr_cnt=0.
- Basic write/read: RFWr=1, WA=5, WD=0x1234ABCD, one edge, then RS1=5 and RS2=5 -> both outputs 0x1234ABCD; wr_cnt=1.
- $0 protection: RFWr=1, WA=0, WD=0xFFFFFFFF -> RS1=0 reads 0; wr_cnt unchanged.
- Read-during-write: reg[8]=0x11; in one cycle RFWr=1, WA=8, WD=0x22, RS1=8 -> RS1out=0x11 before the edge without RF_WB_BYPASS_EN, 0x22 with it; 0x22 after the edge in both builds.
- Reset priority: rst=1 and RFWr=1, WA=31, WD=0x8 in the same cycle -> reg[31]=0 afterwards; wr_cnt=0.
- Counter wrap and $31 link: 65536 writes alternating WA=31 (WD=PC+4 value 0x00003004) and WA=2 -> wr_cnt returns to 0x0000; dbg_addr=31 gives 0x00003004.
